wb_stage_pipe: RTL
==================

Name: wb_stage_pipe

Overview:
- Parametrised successor to the combinational writeback stage: owns the MEM/WB pipeline register and accepts instructions through a valid/ready handshake.
- Tolerates variable-latency load data (WAIT_MEM state), applies lane-select and sign/zero extension, selects ALU result, load data or link address, and drives the register-file write port.
- Provides forwarding/hazard outputs, flush handling and a retire counter.
- Sits between the MEM stage/data-memory response and the register file plus hazard unit.

Parameters:
- DATA_W, 32, datapath width; 32 or 64 only.
- REG_AW, 5, register address width.
- LINK_OFS, 8, added to in_pc when link is selected.
- CNT_W, 32, retire counter width.
- LANE_W, $clog2(DATA_W/8), byte-offset width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  discard held entry; accept blocked this cycle.
- in_valid  in  1  MEM stage offers an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  DATA_W  instruction PC.
- in_result  in  DATA_W  ALU/HI/LO result.
- in_wsel  in  2  0 result, 1 load data, 2 link, 3 reserved (treated as 0).
- in_ext  in  3  extension code (Behaviour).
- in_addr_lo  in  LANE_W  low load-address bits.
- in_is_load  in  1  entry waits for mem_rvalid.
- in_reg_write  in  1  instruction writes a register.
- in_rd  in  REG_AW  destination register.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  DATA_W  raw load word.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  DATA_W  write data.
- fwd_valid  out  1  rf_wdata forwardable.
- fwd_pending  out  1  load to fwd_addr outstanding; hazard unit must stall consumers.
- fwd_addr  out  REG_AW  destination of held entry.
- retire_count  out  CNT_W  retired instructions, wraps.
- err  out  2  sticky flags: [0] misaligned load, [1] unexpected mem_rvalid.

Behaviour:
- States:
  - EMPTY: no entry held.
  - FULL: entry held, write data final.
  - WAIT_MEM: load entry held, data not yet returned.
- Reset: state EMPTY; rf_we, fwd_valid, fwd_pending, retire_count, err all 0; rf_waddr, rf_wdata 0.
- Handshake:
  - in_ready = (state==EMPTY || state==FULL) && !flush.
  - Accept = in_valid && in_ready. On accept all in_* are registered; next state is WAIT_MEM if in_is_load, else FULL.
- FULL:
  - rf_we = reg_write && rd!=0, combinational from the registered entry.
  - The entry retires this cycle: retire_count+1, including rd==0 writes.
  - Next state: FULL/WAIT_MEM if a new entry is accepted the same cycle, else EMPTY. This gives back-to-back throughput of 1 per cycle.
- WAIT_MEM:
  - rf_we=0.
  - When mem_rvalid=1, mem_rdata is extended, the result is registered as write data, and the next state is FULL. Load-use latency is 1 cycle after mem_rvalid.
  - No accept is possible in WAIT_MEM.
- Extension (lane = addr_lo, little-endian):
  - 0: full word pass-through.
  - 1 / 2: byte zero- / sign-extended.
  - 3 / 4: half zero- / sign-extended.
  - 5 / 6: 32-bit zero- / sign-extended (DATA_W=64 only; at 32 these behave as 0).
  - 7: pass-through.
- Misaligned load (half with lane[0]=1, 32-bit with lane[1:0]!=0): lane is aligned down and err[0] is set.
- Link: wdata = in_pc + LINK_OFS, modulo 2^DATA_W.
- Flush:
  - The held entry is dropped with no write and no retire; state goes to EMPTY.
  - If the entry was in WAIT_MEM, a drop_pending flag is set and the next mem_rvalid is swallowed. A flush arriving together with mem_rvalid consumes that response, so drop_pending is not set.
- Stray mem_rvalid (EMPTY/FULL, no drop_pending): ignored; err[1] is set.
- Forwarding:
  - fwd_valid = state==FULL && reg_write && rd!=0.
  - fwd_pending = state==WAIT_MEM && reg_write && rd!=0.
  - fwd_addr = rd of the held entry.
- Asynchronous reset mid-WAIT_MEM: everything clears, drop_pending=0, and any late response sets err[1].

Decomposition:
- Shared package: wsel codes (WSEL_RESULT/WSEL_MEM/WSEL_LINK), ext codes EXT_W..EXT_WS, state encoding.
- Sub-module wb_load_ext: purely combinational lane select and extension, parametrised by DATA_W.
- FSM, register, handshake and counters live in the top.

Test Plan:
- ALU op: in_result=0x1234_5678, wsel=0, rd=3, no load → next cycle rf_we=1, waddr=3, wdata=0x1234_5678; retire_count=1.
- Load byte signed: ext=2, addr_lo=2, mem_rdata=0x0080_0000 returned 3 cycles late → fwd_pending high 3 cycles, then 1 cycle later wdata=0xFFFF_FF80 with rf_we=1.
- Link: pc=0x0040_0010, wsel=2, rd=31 → wdata=0x0040_0018. A write to rd=0 gives rf_we=0 but retire_count still increments.
- Back-to-back: 4 ALU ops with in_valid held high → in_ready stays 1, 4 writes on consecutive cycles.
- Flush in WAIT_MEM, then mem_rvalid → no write, err[1]=0; a second, stray mem_rvalid → err[1]=1.
- Half load with addr_lo=1 → err[0]=1, data taken from lane 0. Reset asserted mid-wait → all outputs 0 immediately.

Source files
------------

// File: rtl/wb_stage_pipe_pkg.sv
// Shared encodings for the writeback pipeline stage. This covers writeback
// source select, load extension codes and the FSM state encoding.
package wb_stage_pipe_pkg;

  localparam logic [1:0] WSEL_RESULT = 2'd0;
  localparam logic [1:0] WSEL_MEM    = 2'd1;
  localparam logic [1:0] WSEL_LINK   = 2'd2;

  localparam logic [2:0] EXT_W  = 3'd0;
  localparam logic [2:0] EXT_BZ = 3'd1;
  localparam logic [2:0] EXT_BS = 3'd2;
  localparam logic [2:0] EXT_HZ = 3'd3;
  localparam logic [2:0] EXT_HS = 3'd4;
  localparam logic [2:0] EXT_WZ = 3'd5;
  localparam logic [2:0] EXT_WS = 3'd6;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FULL     = 2'd1,
    ST_WAIT_MEM = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load lane select and zero/sign extension (little-endian).
// Misaligned half/32-bit accesses are aligned down and flagged.
module wb_load_ext #(
  parameter  int DATA_W = 32,
  localparam int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        ext,
  input  logic [LANE_W-1:0] lane,
  output logic [DATA_W-1:0] data,
  output logic              misaligned
);
  import wb_stage_pipe_pkg::*;

  logic [LANE_W-1:0] lane_h;
  logic [7:0]        b;
  logic [15:0]       h;
  logic [DATA_W-1:0] w_z;
  logic [DATA_W-1:0] w_s;
  logic              w_mis;

  assign lane_h = {lane[LANE_W-1:1], 1'b0};
  assign b      = rdata[{lane, 3'b000} +: 8];
  assign h      = rdata[{lane_h, 3'b000} +: 16];

  // 32-bit extension only exists on a 64-bit datapath; otherwise pass-through.
  generate
    if (DATA_W == 64) begin : g_w64
      logic [31:0] w;
      assign w     = rdata[{lane[LANE_W-1], 5'b00000} +: 32];
      assign w_z   = {32'b0, w};
      assign w_s   = {{32{w[31]}}, w};
      assign w_mis = (lane[1:0] != 2'b00);
    end else begin : g_w32
      assign w_z   = rdata;
      assign w_s   = rdata;
      assign w_mis = 1'b0;
    end
  endgenerate

  always_comb begin
    data       = rdata;
    misaligned = 1'b0;
    case (ext)
      EXT_BZ: data = {{(DATA_W-8){1'b0}}, b};
      EXT_BS: data = {{(DATA_W-8){b[7]}}, b};
      EXT_HZ: begin
        data       = {{(DATA_W-16){1'b0}}, h};
        misaligned = lane[0];
      end
      EXT_HS: begin
        data       = {{(DATA_W-16){h[15]}}, h};
        misaligned = lane[0];
      end
      EXT_WZ: begin
        data       = w_z;
        misaligned = w_mis;
      end
      EXT_WS: begin
        data       = w_s;
        misaligned = w_mis;
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register with valid/ready intake, variable-latency load wait,
// register-file write port, forwarding/hazard outputs, flush and retire counter.
module wb_stage_pipe
  import wb_stage_pipe_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int REG_AW   = 5,
  parameter  int LINK_OFS = 8,
  parameter  int CNT_W    = 32,
  localparam int LANE_W   = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_result,
  input  logic [1:0]        in_wsel,
  input  logic [2:0]        in_ext,
  input  logic [LANE_W-1:0] in_addr_lo,
  input  logic              in_is_load,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic              fwd_pending,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [CNT_W-1:0]  retire_count,
  output logic [1:0]        err,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a cycle where in_valid && in_ready at the
  // rising edge; in_ready never depends on in_valid, only on state and flush.

  wb_state_e         state_q, state_d;
  logic [REG_AW-1:0] e_rd;
  logic              e_we;
  logic [2:0]        e_ext;
  logic [LANE_W-1:0] e_lane;
  logic [DATA_W-1:0] e_wdata;
  logic              drop_pending, drop_pending_d;
  logic              accept, retire, capture, stray;
  logic [DATA_W-1:0] ext_data;
  logic              ext_mis;

  wb_load_ext #(.DATA_W(DATA_W)) u_ext (
    .rdata      (mem_rdata),
    .ext        (e_ext),
    .lane       (e_lane),
    .data       (ext_data),
    .misaligned (ext_mis)
  );

  assign in_ready    = (state_q == ST_EMPTY || state_q == ST_FULL) && !flush;
  assign accept      = in_valid && in_ready;
  assign rf_we       = (state_q == ST_FULL) && e_we && (e_rd != '0) && !flush;
  assign fwd_valid   = (state_q == ST_FULL) && e_we && (e_rd != '0);
  assign fwd_pending = (state_q == ST_WAIT_MEM) && e_we && (e_rd != '0);
  assign fwd_addr    = e_rd;
  assign rf_waddr    = e_rd;
  assign rf_wdata    = e_wdata;
  assign dbg_state   = state_q;

  always_comb begin
    state_d        = state_q;
    retire         = 1'b0;
    capture        = 1'b0;
    drop_pending_d = drop_pending && !mem_rvalid;
    stray          = mem_rvalid && !drop_pending && (state_q != ST_WAIT_MEM);
    case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = in_is_load ? ST_WAIT_MEM : ST_FULL;
      end
      ST_FULL: begin
        if (flush) begin
          state_d = ST_EMPTY;
        end else begin
          retire  = 1'b1;
          state_d = accept ? (in_is_load ? ST_WAIT_MEM : ST_FULL) : ST_EMPTY;
        end
      end
      ST_WAIT_MEM: begin
        if (flush) begin
          state_d = ST_EMPTY;
          // Still owed a response unless this cycle's one belongs to the dropped load.
          drop_pending_d = drop_pending || !mem_rvalid;
        end else if (mem_rvalid && !drop_pending) begin
          capture = 1'b1;
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_EMPTY;
      e_rd         <= '0;
      e_we         <= 1'b0;
      e_ext        <= '0;
      e_lane       <= '0;
      e_wdata      <= '0;
      drop_pending <= 1'b0;
      retire_count <= '0;
      err          <= 2'b00;
    end else begin
      state_q      <= state_d;
      drop_pending <= drop_pending_d;
      if (accept) begin
        e_rd    <= in_rd;
        e_we    <= in_reg_write;
        e_ext   <= in_ext;
        e_lane  <= in_addr_lo;
        e_wdata <= (in_wsel == WSEL_LINK) ? (in_pc + DATA_W'(LINK_OFS)) : in_result;
      end else if (capture) begin
        e_wdata <= ext_data;
      end
      if (capture && ext_mis) err[0] <= 1'b1;
      if (stray) err[1] <= 1'b1;
      if (retire) retire_count <= retire_count + 1'b1;
    end
  end

endmodule
